// File: rtl/if_fetch_if.sv
// Memory-side fetch bus: level-held request with a one-cycle completion pulse.
interface if_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        done;
    logic [31:0] data;

    modport master (output req, output addr, input done, input data);
    modport slave  (input req, input addr, output done, output data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/done bus and
// feeds IF/ID, handling stall hold-off, EX redirects and stale-fetch discard.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_req_i,
    input  logic [31:0]       jump_addr_i,
    if_fetch_if.master        mem,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH, FULL} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_q, req_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] pc_out_q, pc_out_n;
    logic [31:0] inst_q, inst_n;
    logic        valid_q, valid_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_inst, buf_inst_n;

    logic [31:0] target;
    logic        present;
    logic [31:0] present_pc;
    logic [31:0] present_inst;

    assign target = jump_addr_i & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            pc_out_q <= '0;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
            buf_pc   <= '0;
            buf_inst <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            pc_out_q <= pc_out_n;
            inst_q   <= inst_n;
            valid_q  <= valid_n;
            buf_pc   <= buf_pc_n;
            buf_inst <= buf_inst_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_n        = req_q;
        addr_n       = addr_q;
        buf_pc_n     = buf_pc;
        buf_inst_n   = buf_inst;
        present      = 1'b0;
        present_pc   = pc;
        present_inst = NOP_INST;

        case (state)
            IDLE: begin
                if (jump_req_i) begin
                    pc_n = target;
                end else begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (mem.done) begin
                    req_n = 1'b0;
                    if (jump_req_i) begin
                        pc_n    = target;
                        state_n = IDLE;
                    end else if (!stall_i) begin
                        present      = 1'b1;
                        present_pc   = pc;
                        present_inst = mem.data;
                        pc_n         = pc + 32'd4;
                        state_n      = IDLE;
                    end else begin
                        buf_pc_n   = pc;
                        buf_inst_n = mem.data;
                        state_n    = FULL;
                    end
                end else if (jump_req_i) begin
                    // The request cannot be aborted; let it finish and drop it.
                    pc_n    = target;
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (jump_req_i) begin
                    pc_n = target;
                end
                if (mem.done) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            FULL: begin
                if (jump_req_i) begin
                    pc_n       = target;
                    buf_pc_n   = '0;
                    buf_inst_n = '0;
                    state_n    = IDLE;
                end else if (!stall_i) begin
                    present      = 1'b1;
                    present_pc   = buf_pc;
                    present_inst = buf_inst;
                    pc_n         = buf_pc + 32'd4;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    // Redirect beats a fresh instruction, which beats a stall hold.
    always_comb begin
        pc_out_n = pc_out_q;
        inst_n   = inst_q;
        valid_n  = valid_q;
        if (jump_req_i) begin
            inst_n  = NOP_INST;
            valid_n = 1'b0;
        end else if (present) begin
            pc_out_n = present_pc;
            inst_n   = present_inst;
            valid_n  = 1'b1;
        end else if (!stall_i) begin
            inst_n  = NOP_INST;
            valid_n = 1'b0;
        end
    end

    assign mem.req      = req_q;
    assign mem.addr     = addr_q;
    assign pc_o         = pc_out_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a memory responder plus an architectural
// program-counter model checking fetch addresses, delivered words and hold rules.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid;

    if_fetch_if mem ();

    if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .jump_req_i   (jump),
        .jump_addr_i  (jaddr),
        .mem          (mem),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] arch_pc;
    int          lat;
    bit          pending;
    int          deliveries;
    logic        p_jump, p_stall, p_req, p_done, p_valid;
    logic [31:0] p_jaddr, p_pc, p_inst, p_addr;

    // Memory contents as a function of address; word 0 is addi x1,x0,5.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, mem.req}, 32'd0);
        chk({tag, "_addr"},  mem.addr, 32'd0);
        chk({tag, "_pc"},    pc_o, 32'd0);
        chk({tag, "_inst"},  inst_o, NOP);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic model_reset();
        arch_pc  = RESET_PC;
        pending  = 1'b0;
        lat      = 0;
        stall    = 1'b0;
        jump     = 1'b0;
        jaddr    = '0;
        mem.done = 1'b0;
        mem.data = '0;
        p_jump   = 1'b0;
        p_stall  = 1'b0;
        p_req    = 1'b0;
        p_done   = 1'b0;
        p_valid  = 1'b0;
        p_jaddr  = '0;
        p_pc     = '0;
        p_inst   = NOP;
        p_addr   = '0;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 1023));
        endcase
    endfunction

    // One clock: check what the previous edge did, then drive the next edge.
    task automatic step(input int stall_pct, input int jump_pct);
        @(posedge clk);
        #1;
        if (p_jump) begin
            chk("jump_valid", {31'd0, valid}, 32'd0);
            chk("jump_inst", inst_o, NOP);
            arch_pc = p_jaddr & ~32'h3;
        end else if (p_stall) begin
            chk("hold_pc", pc_o, p_pc);
            chk("hold_inst", inst_o, p_inst);
            chk("hold_valid", {31'd0, valid}, {31'd0, p_valid});
        end else if (valid) begin
            chk("deliver_pc", pc_o, arch_pc);
            chk("deliver_inst", inst_o, word_at(arch_pc));
            arch_pc = arch_pc + 32'd4;
            deliveries++;
        end else begin
            chk("idle_inst", inst_o, NOP);
            chk("idle_pc_hold", pc_o, p_pc);
        end

        if (!p_req && mem.req) begin
            chk("req_addr", mem.addr, arch_pc);
            pending = 1'b1;
            lat     = $urandom_range(0, 3);
        end
        if (p_req && mem.req)
            chk("addr_stable", mem.addr, p_addr);
        if (p_req && !mem.req)
            chk("req_drop_needs_done", {31'd0, p_done}, 32'd1);
        if (p_req && p_done)
            chk("req_low_after_done", {31'd0, mem.req}, 32'd0);

        mem.done = 1'b0;
        if (pending) begin
            if (lat == 0) begin
                mem.done = 1'b1;
                mem.data = word_at(mem.addr);
                pending  = 1'b0;
            end else begin
                lat--;
            end
        end else if (!mem.req && $urandom_range(0, 15) == 0) begin
            mem.done = 1'b1;
            mem.data = $urandom;
        end
        stall = ($urandom_range(0, 99) < stall_pct);
        jump  = ($urandom_range(0, 99) < jump_pct);
        jaddr = pick_target();

        p_jump  = jump;
        p_stall = stall;
        p_jaddr = jaddr;
        p_done  = mem.done;
        p_req   = mem.req;
        p_addr  = mem.addr;
        p_pc    = pc_o;
        p_inst  = inst_o;
        p_valid = valid;
    endtask

    initial begin
        int d0;
        bit busy_seen;
        model_reset();
        deliveries = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) step(0, 0);
        chk("free_run_progress", {31'd0, deliveries >= 5}, 32'd1);

        d0 = deliveries;
        for (int i = 0; i < 200; i++) step(50, 0);
        chk("stall_progress", {31'd0, deliveries > d0}, 32'd1);

        d0 = deliveries;
        for (int i = 0; i < 400; i++) step(30, 10);
        chk("jump_progress", {31'd0, deliveries > d0}, 32'd1);

        busy_seen = 1'b0;
        for (int i = 0; i < 50 && !busy_seen; i++) begin
            step(0, 0);
            busy_seen = mem.req && pending;
        end
        chk("busy_before_reset", {31'd0, busy_seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        d0 = deliveries;
        for (int i = 0; i < 300; i++) step(20, 5);
        chk("final_progress", {31'd0, deliveries > d0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
